// File: rtl/apb_timer_responder.sv
// APB3 completer with a 32-bit compare/auto-reload timer and a level interrupt.
// Optional prescaler is built when APB_TIMER_PRESCALER_EN is defined.
module apb_timer_responder #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'h54494D31
) (
    input  logic        io_systemClk,
    input  logic        io_asyncResetn,
    input  logic [15:0] io_apbSlave_0_PADDR,
    input  logic        io_apbSlave_0_PSEL,
    input  logic        io_apbSlave_0_PENABLE,
    input  logic        io_apbSlave_0_PWRITE,
    input  logic [31:0] io_apbSlave_0_PWDATA,
    output logic [31:0] io_apbSlave_0_PRDATA,
    output logic        io_apbSlave_0_PREADY,
    output logic        io_apbSlave_0_PSLVERROR,
    output logic        o_irq,
    output logic        o_match
);

    localparam logic [7:0] OFF_CTRL     = 8'h00;
    localparam logic [7:0] OFF_STATUS   = 8'h04;
    localparam logic [7:0] OFF_COUNT    = 8'h08;
    localparam logic [7:0] OFF_COMPARE  = 8'h0C;
    localparam logic [7:0] OFF_PRESCALE = 8'h10;
    localparam logic [7:0] OFF_ID       = 8'h14;
    localparam logic [3:0] WS_INIT      = 4'(WAIT_STATES);

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  ws_q, ws_d;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        status_q, status_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        irq_q, irq_d;
    logic        match_q, match_d;

    logic [7:0]  offset;
    logic [31:0] rd_val;
    logic        addr_hit;
    logic        acc_err;
    logic        done;
    logic        wr_commit;
    logic        tick;
    logic        unused_paddr;

    assign offset       = io_apbSlave_0_PADDR[7:0];
    assign unused_paddr = ^io_apbSlave_0_PADDR[15:8];

`ifdef APB_TIMER_PRESCALER_EN
    logic [15:0] prescale_q, prescale_d;
    logic [15:0] psc_cnt_q, psc_cnt_d;
`endif

    // Only word-aligned offsets appear below, so misaligned addresses fall into default.
    always_comb begin
        addr_hit = 1'b1;
        rd_val   = '0;
        case (offset)
            OFF_CTRL:     rd_val = {29'b0, ctrl_q};
            OFF_STATUS:   rd_val = {31'b0, status_q};
            OFF_COUNT:    rd_val = count_q;
            OFF_COMPARE:  rd_val = compare_q;
`ifdef APB_TIMER_PRESCALER_EN
            OFF_PRESCALE: rd_val = {16'b0, prescale_q};
`endif
            OFF_ID:       rd_val = ID_VALUE;
            default:      addr_hit = 1'b0;
        endcase
        acc_err = !addr_hit || (io_apbSlave_0_PWRITE && offset == OFF_ID);
    end

    // APB FSM: state register
    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            state_q <= ST_IDLE;
            ws_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ws_q    <= ws_d;
            rdata_q <= acc_err ? 32'b0 : rd_val;
            err_q   <= acc_err;
        end
    end

    // APB FSM: next state
    always_comb begin
        state_d = state_q;
        ws_d    = ws_q;
        case (state_q)
            ST_IDLE: begin
                if (io_apbSlave_0_PSEL) begin
                    state_d = ST_ACCESS;
                    ws_d    = WS_INIT;
                end
            end
            ST_ACCESS: begin
                if (!io_apbSlave_0_PSEL) begin
                    state_d = ST_IDLE;
                end else if (io_apbSlave_0_PENABLE) begin
                    if (ws_q == 4'd0) state_d = ST_IDLE;
                    else              ws_d    = ws_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // APB FSM: outputs
    always_comb begin
        done = (state_q == ST_ACCESS) && io_apbSlave_0_PSEL && io_apbSlave_0_PENABLE
               && (ws_q == 4'd0);
        wr_commit               = done && io_apbSlave_0_PWRITE && !err_q;
        io_apbSlave_0_PREADY    = done;
        io_apbSlave_0_PRDATA    = done ? rdata_q : 32'b0;
        io_apbSlave_0_PSLVERROR = done && err_q;
    end

`ifdef APB_TIMER_PRESCALER_EN
    assign tick = (psc_cnt_q == prescale_q);

    always_comb begin
        prescale_d = prescale_q;
        psc_cnt_d  = psc_cnt_q;
        if (!ctrl_q[0])  psc_cnt_d = '0;
        else if (tick)   psc_cnt_d = '0;
        else             psc_cnt_d = psc_cnt_q + 16'd1;
        if (wr_commit && offset == OFF_PRESCALE) begin
            prescale_d = io_apbSlave_0_PWDATA[15:0];
            psc_cnt_d  = '0;
        end
    end

    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            prescale_q <= '0;
            psc_cnt_q  <= '0;
        end else begin
            prescale_q <= prescale_d;
            psc_cnt_q  <= psc_cnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Bus writes override the counter step; a new match overrides a same-cycle W1C.
    always_comb begin
        ctrl_d    = ctrl_q;
        status_d  = status_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = 1'b0;
        irq_d     = status_q & ctrl_q[2];
        if (ctrl_q[0] && tick) begin
            if (count_q == compare_q) begin
                match_d = 1'b1;
                count_d = ctrl_q[1] ? 32'b0 : count_q + 32'd1;
            end else begin
                count_d = count_q + 32'd1;
            end
        end
        if (wr_commit) begin
            case (offset)
                OFF_CTRL:    ctrl_d    = io_apbSlave_0_PWDATA[2:0];
                OFF_STATUS:  if (io_apbSlave_0_PWDATA[0]) status_d = 1'b0;
                OFF_COUNT:   count_d   = io_apbSlave_0_PWDATA;
                OFF_COMPARE: compare_d = io_apbSlave_0_PWDATA;
                default: ;
            endcase
        end
        if (match_d) status_d = 1'b1;
    end

    always_ff @(posedge io_systemClk or negedge io_asyncResetn) begin
        if (!io_asyncResetn) begin
            ctrl_q    <= '0;
            status_q  <= 1'b0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            irq_q     <= 1'b0;
            match_q   <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            status_q  <= status_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            irq_q     <= irq_d;
            match_q   <= match_d;
        end
    end

    assign o_irq   = irq_q;
    assign o_match = match_q;

endmodule

// File: tb/tb_apb_timer_responder.sv
// Scoreboard bench for apb_timer_responder built with WAIT_STATES=2.
module tb_apb_timer_responder;

    localparam logic [31:0] ID = 32'h54494D31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata, prdata;
    logic        pready, pslverr, irq, match;

    always #5 clk = ~clk;

    apb_timer_responder #(.WAIT_STATES(2), .ID_VALUE(ID)) dut (
        .io_systemClk            (clk),
        .io_asyncResetn          (rst_n),
        .io_apbSlave_0_PADDR     (paddr),
        .io_apbSlave_0_PSEL      (psel),
        .io_apbSlave_0_PENABLE   (penable),
        .io_apbSlave_0_PWRITE    (pwrite),
        .io_apbSlave_0_PWDATA    (pwdata),
        .io_apbSlave_0_PRDATA    (prdata),
        .io_apbSlave_0_PREADY    (pready),
        .io_apbSlave_0_PSLVERROR (pslverr),
        .o_irq                   (irq),
        .o_match                 (match)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { string name; logic [31:0] data; logic err; logic chk; } exp_t;
    typedef struct { logic [31:0] data; logic err; int waits; } obs_t;
    exp_t exp_q[$];
    obs_t obs_q[$];

    task automatic expect_txn(input string name, input logic [31:0] data,
                              input logic err, input logic chk);
        exp_t e;
        e.name = name; e.data = data; e.err = err; e.chk = chk;
        exp_q.push_back(e);
    endtask

    // One APB transfer; leaves the bus idle just after the completion edge.
    task automatic apb_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata);
        obs_t o;
        int   w;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        w = 0;
        forever begin
            @(negedge clk);
            if (pready === 1'b1) break;
            w++;
            if (w > 20) break;
            @(posedge clk); #1;
        end
        o.data  = prdata;
        o.err   = pslverr;
        o.waits = (w > 20) ? -1 : w;
        $display("txn %s addr=%h wdata=%h rdata=%h err=%b waits=%0d",
                 wr ? "WR" : "RD", addr, wdata, o.data, o.err, o.waits);
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        obs_q.push_back(o);
    endtask

    task automatic test_reset();
        exp_t e;
        obs_t o;
        rst_n = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        paddr = 16'h0014; pwdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (pready !== 1'b0 || prdata !== 32'b0 || pslverr !== 1'b0 || irq !== 1'b0 || match !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b rdata=%h err=%b irq=%b match=%b, want all zero",
                     pready, prdata, pslverr, irq, match);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge clk); #1; rst_n = 1'b1;
        expect_txn("rst_compare", 32'hFFFF_FFFF, 1'b0, 1'b1); apb_xfer(1'b0, 16'h000C, 0);
        expect_txn("rst_id",      ID,            1'b0, 1'b1); apb_xfer(1'b0, 16'h0014, 0);
        expect_txn("rst_ctrl",    32'h0,         1'b0, 1'b1); apb_xfer(1'b0, 16'h0000, 0);
        expect_txn("rst_status",  32'h0,         1'b0, 1'b1); apb_xfer(1'b0, 16'h0004, 0);
        expect_txn("rst_count",   32'h0,         1'b0, 1'b1); apb_xfer(1'b0, 16'h0008, 0);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.err !== e.err || o.waits !== 2 || (e.chk && o.data !== e.data)) begin
                errors++;
                $display("FAIL %s: got data=%h err=%b waits=%0d, want data=%h err=%b waits=2",
                         e.name, o.data, o.err, o.waits, e.data, e.err);
            end
        end
    endtask

    task automatic test_errors();
        exp_t e;
        obs_t o;
        expect_txn("unmapped_rd",   32'h0, 1'b1, 1'b1); apb_xfer(1'b0, 16'h0020, 0);
        expect_txn("misaligned_rd", 32'h0, 1'b1, 1'b1); apb_xfer(1'b0, 16'h0006, 0);
        expect_txn("misaligned_wr", 32'h0, 1'b1, 1'b0); apb_xfer(1'b1, 16'h000D, 32'h1234);
        expect_txn("compare_kept",  32'hFFFF_FFFF, 1'b0, 1'b1); apb_xfer(1'b0, 16'h000C, 0);
        expect_txn("id_wr",         32'h0, 1'b1, 1'b0); apb_xfer(1'b1, 16'h0014, 32'h0);
        expect_txn("id_unchanged",  ID,    1'b0, 1'b1); apb_xfer(1'b0, 16'h0014, 0);
        expect_txn("upper_ignored", ID,    1'b0, 1'b1); apb_xfer(1'b0, 16'hAB14, 0);
`ifndef APB_TIMER_PRESCALER_EN
        expect_txn("psc_rd_unmapped", 32'h0, 1'b1, 1'b1); apb_xfer(1'b0, 16'h0010, 0);
        expect_txn("psc_wr_unmapped", 32'h0, 1'b1, 1'b0); apb_xfer(1'b1, 16'h0010, 32'h3);
`endif
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.err !== e.err || o.waits !== 2 || (e.chk && o.data !== e.data)) begin
                errors++;
                $display("FAIL %s: got data=%h err=%b waits=%0d, want data=%h err=%b waits=2",
                         e.name, o.data, o.err, o.waits, e.data, e.err);
            end
        end
    endtask

    task automatic test_auto_reload();
        exp_t e;
        obs_t o;
        int   pulses, first, second;
        logic irq_at[14];
        expect_txn("wr_count0",  0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0008, 32'd0);
        expect_txn("wr_cmp5",    0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h000C, 32'd5);
        expect_txn("wr_ctrl7",   0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0000, 32'h7);
        pulses = 0; first = -1; second = -1;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            irq_at[i] = irq;
            if (match === 1'b1) begin
                pulses++;
                if (first < 0) first = i; else if (second < 0) second = i;
            end
        end
        checks++;
        if (pulses !== 2 || first !== 6 || second !== 12) begin
            errors++;
            $display("FAIL match_pulses: got count=%0d at %0d,%0d, want count=2 at 6,12", pulses, first, second);
        end
        checks++;
        if (irq_at[6] !== 1'b0 || irq_at[7] !== 1'b1) begin
            errors++;
            $display("FAIL irq_rise: got %b,%b at 6,7, want 0,1", irq_at[6], irq_at[7]);
        end
        expect_txn("wr_ctrl_stop", 0,     1'b0, 1'b0); apb_xfer(1'b1, 16'h0000, 32'hFFFF_FFFC);
        expect_txn("rd_ctrl_mask", 32'h4, 1'b0, 1'b1); apb_xfer(1'b0, 16'h0000, 0);
        expect_txn("rd_status1",   32'h1, 1'b0, 1'b1); apb_xfer(1'b0, 16'h0004, 0);
        expect_txn("w1c_status",   0,     1'b0, 1'b0); apb_xfer(1'b1, 16'h0004, 32'h1);
        @(negedge clk);
        checks++;
        if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", irq); end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", irq); end
        expect_txn("rd_status0",   32'h0, 1'b0, 1'b1); apb_xfer(1'b0, 16'h0004, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.err !== e.err || o.waits !== 2 || (e.chk && o.data !== e.data)) begin
                errors++;
                $display("FAIL %s: got data=%h err=%b waits=%0d, want data=%h err=%b waits=2",
                         e.name, o.data, o.err, o.waits, e.data, e.err);
            end
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        obs_t o;
        // Match lands on the commit edge of the W1C that follows the enable.
        expect_txn("wr_ctrl_off", 0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0000, 32'h0);
        expect_txn("wr_count0",   0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0008, 32'd0);
        expect_txn("wr_cmp4",     0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h000C, 32'd4);
        expect_txn("wr_ctrl_en",  0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0000, 32'h1);
        expect_txn("w1c_collide", 0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0004, 32'h1);
        expect_txn("status_set_wins", 32'h1, 1'b0, 1'b1); apb_xfer(1'b0, 16'h0004, 0);
        expect_txn("w1c_plain",   0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0004, 32'h1);
        expect_txn("status_cleared", 32'h0, 1'b0, 1'b1); apb_xfer(1'b0, 16'h0004, 0);
        expect_txn("wr_cmp_max",  0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h000C, 32'hFFFF_FFFF);
        expect_txn("wr_count100", 0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0008, 32'd100);
        expect_txn("count_after_wr", 32'd103, 1'b0, 1'b1); apb_xfer(1'b0, 16'h0008, 0);
        expect_txn("count_running",  32'd108, 1'b0, 1'b1); apb_xfer(1'b0, 16'h0008, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.err !== e.err || o.waits !== 2 || (e.chk && o.data !== e.data)) begin
                errors++;
                $display("FAIL %s: got data=%h err=%b waits=%0d, want data=%h err=%b waits=2",
                         e.name, o.data, o.err, o.waits, e.data, e.err);
            end
        end
    endtask

`ifdef APB_TIMER_PRESCALER_EN
    task automatic test_prescaler();
        exp_t e;
        obs_t o;
        int   pulses, first;
        expect_txn("wr_ctrl_off", 0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0000, 32'h0);
        expect_txn("wr_count0",   0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0008, 32'd0);
        expect_txn("wr_psc3",     0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0010, 32'd3);
        expect_txn("rd_psc3",     32'd3, 1'b0, 1'b1); apb_xfer(1'b0, 16'h0010, 0);
        expect_txn("wr_cmp2",     0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h000C, 32'd2);
        expect_txn("wr_ctrl3",    0, 1'b0, 1'b0); apb_xfer(1'b1, 16'h0000, 32'h3);
        pulses = 0; first = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (match === 1'b1) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (pulses !== 1 || first !== 12) begin
            errors++;
            $display("FAIL psc_match: got count=%0d first=%0d, want count=1 first=12", pulses, first);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.err !== e.err || o.waits !== 2 || (e.chk && o.data !== e.data)) begin
                errors++;
                $display("FAIL %s: got data=%h err=%b waits=%0d, want data=%h err=%b waits=2",
                         e.name, o.data, o.err, o.waits, e.data, e.err);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_errors();
        test_auto_reload();
        test_simultaneous();
`ifdef APB_TIMER_PRESCALER_EN
        test_prescaler();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
